operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Parametrised successor to the ALU operand/opcode front end: captures operand A, operand B and the opcode from board switches under push-button control.
- Adds per-button synchronisation, debounce and rising-edge detection, so one physical press causes exactly one load.
- Adds a sequential entry mode driven by an FSM, and a "all operands loaded" status flag.
- Sits between board I/O (switches, buttons) and the ALU datapath.

Parameters:
- NB_DATA, 8: width of switches, o_data_a and o_data_b.
- NB_OP, 6: opcode width. Constraint: NB_OP <= NB_DATA.
- DB_CYCLES, 16: consecutive stable cycles required to accept a button level change. Set to about 1_000_000 for the board build.
- NB_DB, 20: debounce counter width. Constraint: 2^NB_DB > DB_CYCLES.

Ports:
- i_clock  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_mode  in  1  entry mode: 0 = direct, 1 = sequential.
- i_buttons  in  3  raw asynchronous push-buttons, active-high.
- i_switches  in  NB_DATA  raw switch value (signed).
- o_data_a  out  NB_DATA  operand A (signed).
- o_data_b  out  NB_DATA  operand B (signed).
- o_operation  out  NB_OP  opcode.
- o_state  out  2  sequential FSM state: 0 = S_A, 1 = S_B, 2 = S_OP, 3 = S_DONE.
- o_valid  out  1  high while A, B and OP have all been written since the last reset or clear.
- o_load_pulse  out  1  one-cycle pulse, coincident with any register write.

Behaviour:
- Reset (i_reset == 0 at a clock edge) clears:
  - all outputs to 0; FSM to S_A;
  - loaded flags, synchronisers, debounce counters and stable levels.
- Per-button input path:
  - 2-FF synchroniser, then debounce.
  - Debounce counter increments while the synchronised level differs from the stable level, and resets to 0 whenever they match.
  - When the counter reaches DB_CYCLES, the stable level takes the new value and the counter resets.
  - press[i] = stable rising edge: a 1-cycle pulse.
- Latency: a clean press, first sampled high at edge k, updates the target register at edge k+DB_CYCLES+3.
- Glitches shorter than DB_CYCLES cycles produce no press. Releases produce no press.
- Switches are not synchronised: they are sampled at the load edge and must be static during the press.
- A button held through reset release yields exactly one press once debounced.
- Direct mode (i_mode = 0):
  - press[0] loads A; press[1] loads B; press[2] loads OP from i_switches[NB_OP-1:0].
  - Simultaneous presses all take effect in the same cycle.
  - Each load sets its loaded flag.
  - The FSM holds its state.
- Sequential mode (i_mode = 1). Buttons act as press[0] = enter, press[1] = back, press[2] = clear.
  - Priority when presses coincide: clear > enter > back.
  - clear: A, B, OP and all flags go to 0; FSM to S_A; o_load_pulse stays 0.
  - enter:
    - S_A: load A, go to S_B.
    - S_B: load B, go to S_OP.
    - S_OP: load OP, go to S_DONE.
    - S_DONE: clear the flags only (registers retained), go to S_A, no load.
  - back: S_B -> S_A; S_OP -> S_B; S_A and S_DONE unchanged; no load.
- Mode change:
  - The registered i_mode is compared with the current i_mode. A toggle forces the FSM to S_A in that cycle, and any press in that cycle is ignored.
  - Registers and flags are retained.
- o_valid = flag_a & flag_b & flag_op, registered; updates in the same cycle as the final write.
- o_load_pulse is registered alongside the data write; it never exceeds 1 cycle per press.
- All data is loaded verbatim; no sign extension or truncation except the OP slice.

Test Plan:
- Reset with i_reset = 0 while buttons are held and switches = 8'hFF -> all outputs 0, o_state = 0. After release, a held button gives a single load at debounce latency.
- Direct mode, DB_CYCLES = 4: switches = 8'h85, hold btn0 for 20 cycles -> o_data_a = 8'h85 exactly 7 edges after the first high sample. One o_load_pulse only. A 3-cycle glitch on btn1 -> o_data_b unchanged.
- Direct mode, btn0 + btn1 + btn2 pressed simultaneously with switches = 8'h3A -> A = B = 8'h3A, OP = 6'h3A, o_valid = 1 in the same cycle.
- Sequential mode: enter with 8'h05, then 8'hFB, then 8'h20 -> A = 5, B = -5, OP = 6'h20, o_state = 3, o_valid = 1. Another enter -> o_state = 0, o_valid = 0, data retained.
- Sequential mode: in S_OP press back -> S_B, no write. Enter + clear pressed together -> all zero, S_A.
- Toggle i_mode while in S_OP with a press landing in the same cycle -> FSM goes to S_A, no register write, flags retained.

Source files
------------

// File: rtl/operand_loader.sv
// operand_loader: captures ALU operands A, B and the opcode from board switches
// under push-button control. Every button passes through a synchroniser,
// debouncer and rising-edge detector, so one physical press gives one load.
// Two entry modes are supported:
//   direct     - each button loads its own register;
//   sequential - a small FSM steps through A -> B -> OP with enter/back/clear.

// One button lane: 2-FF synchroniser, debounce and a single-cycle press pulse.
module operand_loader_btn #(
  parameter int DB_CYCLES = 16,
  parameter int NB_DB     = 20
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);
  localparam logic [NB_DB-1:0] DB_MAX = NB_DB'(DB_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic [NB_DB-1:0] cnt_q, cnt_d;

  // Count cycles the synchronised level disagrees with the accepted level;
  // accept the new level once the disagreement has lasted DB_CYCLES.
  always_comb begin
    sync1_d      = i_btn;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == DB_MAX) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
    end
  end

  // Only a rising edge of the debounced level is a press; releases are ignored.
  assign o_press = stable_q & ~stable_dly_q;
endmodule

module operand_loader #(
  parameter int NB_DATA   = 8,
  parameter int NB_OP     = 6,
  parameter int DB_CYCLES = 16,
  parameter int NB_DB     = 20
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_mode,
  input  logic [2:0]         i_buttons,
  input  logic [NB_DATA-1:0] i_switches,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_operation,
  output logic [1:0]         o_state,
  output logic               o_valid,
  output logic               o_load_pulse
);
  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_OP = 2'd2, S_DONE = 2'd3} state_t;

  logic [2:0] press;

  // One debounce lane per button.
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    operand_loader_btn #(
      .DB_CYCLES(DB_CYCLES),
      .NB_DB    (NB_DB)
    ) u_btn (
      .i_clock(i_clock),
      .i_reset(i_reset),
      .i_btn  (i_buttons[gi]),
      .o_press(press[gi])
    );
  end

  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               fa_q, fa_d, fb_q, fb_d, fop_q, fop_d;
  logic               valid_q, valid_d, pulse_q, pulse_d;
  logic               mode_q, mode_d;
  state_t             state_q, state_d;
  logic               toggle;

  assign toggle = mode_q ^ i_mode;

  // Next-state: a mode toggle parks the FSM at S_A and swallows any press that
  // lands in the same cycle; otherwise direct or sequential rules apply.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fop_d   = fop_q;
    state_d = state_q;
    pulse_d = 1'b0;
    mode_d  = i_mode;
    if (toggle) begin
      state_d = S_A;
    end else if (!i_mode) begin
      if (press[0]) begin
        a_d  = i_switches;
        fa_d = 1'b1;
      end
      if (press[1]) begin
        b_d  = i_switches;
        fb_d = 1'b1;
      end
      if (press[2]) begin
        op_d  = i_switches[NB_OP-1:0];
        fop_d = 1'b1;
      end
      pulse_d = |press;
    end else if (press[2]) begin
      // clear wins over enter and back
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      fa_d    = 1'b0;
      fb_d    = 1'b0;
      fop_d   = 1'b0;
      state_d = S_A;
    end else if (press[0]) begin
      case (state_q)
        S_A: begin
          a_d     = i_switches;
          fa_d    = 1'b1;
          state_d = S_B;
          pulse_d = 1'b1;
        end
        S_B: begin
          b_d     = i_switches;
          fb_d    = 1'b1;
          state_d = S_OP;
          pulse_d = 1'b1;
        end
        S_OP: begin
          op_d    = i_switches[NB_OP-1:0];
          fop_d   = 1'b1;
          state_d = S_DONE;
          pulse_d = 1'b1;
        end
        default: begin
          // enter from DONE starts a new round: forget flags, keep data
          fa_d    = 1'b0;
          fb_d    = 1'b0;
          fop_d   = 1'b0;
          state_d = S_A;
        end
      endcase
    end else if (press[1]) begin
      case (state_q)
        S_B:     state_d = S_A;
        S_OP:    state_d = S_B;
        default: state_d = state_q;
      endcase
    end
    valid_d = fa_d & fb_d & fop_d;
  end

  // Datapath, flag and FSM registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      fa_q    <= 1'b0;
      fb_q    <= 1'b0;
      fop_q   <= 1'b0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      mode_q  <= 1'b0;
      state_q <= S_A;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fop_q   <= fop_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      mode_q  <= mode_d;
      state_q <= state_d;
    end
  end

  assign o_data_a     = a_q;
  assign o_data_b     = b_q;
  assign o_operation  = op_q;
  assign o_state      = state_q;
  assign o_valid      = valid_q;
  assign o_load_pulse = pulse_q;
endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed scenarios followed by random button
// transactions, compared cycle by cycle against a transaction-level model.
module tb_operand_loader;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int DB      = 4;
  localparam int NB_DB   = 20;
  localparam int LD      = DB + 4;   // edge index (first high sample = 1) of the load
  localparam int GAP     = DB + 8;   // idle edges after release

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               mode = 1'b0;
  logic [2:0]         btn = 3'b000;
  logic [NB_DATA-1:0] sw = '0;
  logic [NB_DATA-1:0] o_data_a, o_data_b;
  logic [NB_OP-1:0]   o_operation;
  logic [1:0]         o_state;
  logic               o_valid, o_load_pulse;

  operand_loader #(
    .NB_DATA  (NB_DATA),
    .NB_OP    (NB_OP),
    .DB_CYCLES(DB),
    .NB_DB    (NB_DB)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_mode      (mode),
    .i_buttons   (btn),
    .i_switches  (sw),
    .o_data_a    (o_data_a),
    .o_data_b    (o_data_b),
    .o_operation (o_operation),
    .o_state     (o_state),
    .o_valid     (o_valid),
    .o_load_pulse(o_load_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural state only.
  logic [7:0] m_a, m_b;
  logic [5:0] m_op;
  logic       m_fa, m_fb, m_fo, m_mode;
  logic [1:0] m_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [24:0] m_vec();
    return {m_a, m_b, m_op, m_st, m_fa & m_fb & m_fo};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {o_data_a, o_data_b, o_operation, o_state, o_valid};
  endfunction

  task automatic m_reset();
    m_a = '0; m_b = '0; m_op = '0;
    m_fa = 0; m_fb = 0; m_fo = 0; m_st = 0;
  endtask

  // Effect of one accepted press set on the model; reports whether a write happens.
  task automatic apply(input logic [2:0] mask, input logic [7:0] v, output logic wr);
    wr = 0;
    if (!m_mode) begin
      if (mask[0]) begin m_a = v; m_fa = 1; end
      if (mask[1]) begin m_b = v; m_fb = 1; end
      if (mask[2]) begin m_op = v[5:0]; m_fo = 1; end
      wr = (mask != 0);
    end else if (mask[2]) begin
      m_reset();
    end else if (mask[0]) begin
      case (m_st)
        2'd0: begin m_a = v; m_fa = 1; m_st = 1; wr = 1; end
        2'd1: begin m_b = v; m_fb = 1; m_st = 2; wr = 1; end
        2'd2: begin m_op = v[5:0]; m_fo = 1; m_st = 3; wr = 1; end
        default: begin m_fa = 0; m_fb = 0; m_fo = 0; m_st = 0; end
      endcase
    end else if (mask[1]) begin
      if (m_st == 2'd1) m_st = 0;
      else if (m_st == 2'd2) m_st = 1;
    end
  endtask

  // Hold 'mask' for h edges with switches at v, then idle; optionally flip the
  // mode so that it lands on the load edge, optionally release reset at start.
  task automatic do_press(input logic [2:0] mask, input logic [7:0] v, input int h,
                          input bit tog, input bit rel_rst);
    logic [24:0] old_v, new_v;
    logic        wr;
    wr    = 0;
    old_v = m_vec();
    if (tog) begin
      m_mode = ~m_mode;
      m_st   = 0;
    end else if (h > DB) begin
      apply(mask, v, wr);
    end
    new_v = m_vec();
    for (int e = 1; e <= h + GAP; e++) begin
      @(negedge clk);
      if (e == 1) begin
        btn = mask;
        sw  = v;
        if (rel_rst) rst_n = 1'b1;
      end
      if (e == h + 1) btn = 3'b000;
      if (tog && e == LD) mode = ~mode;
      @(posedge clk);
      #1;
      chk("pulse", {31'd0, o_load_pulse}, {31'd0, (e == LD) && wr});
      chk("outs", {7'd0, dut_vec()}, {7'd0, (e >= LD) ? new_v : old_v});
    end
  endtask

  task automatic set_mode(input logic v);
    @(negedge clk);
    if (v != m_mode) m_st = 0;
    m_mode = v;
    mode   = v;
    @(posedge clk);
    #1;
    chk("mode_sw", {7'd0, dut_vec()}, {7'd0, m_vec()});
  endtask

  initial begin
    logic [2:0] mk;
    int         h;
    bit         tg;
    m_reset();
    m_mode = 0;

    // Reset with all buttons held and switches high.
    rst_n = 1'b0; btn = 3'b111; sw = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_outs", {7'd0, dut_vec()}, 32'd0);
    chk("rst_pulse", {31'd0, o_load_pulse}, 32'd0);
    // Held button through reset release: one load at debounce latency.
    do_press(3'b111, 8'hFF, 20, 0, 1);

    // Direct mode.
    do_press(3'b001, 8'h85, 20, 0, 0);
    chk("a_85", {24'd0, o_data_a}, 32'h85);
    do_press(3'b010, 8'h55, 3, 0, 0);        // glitch
    chk("b_glitch", {24'd0, o_data_b}, 32'hFF);
    do_press(3'b111, 8'h3A, 8, 0, 0);
    chk("sim_op", {26'd0, o_operation}, 32'h3A);

    // Sequential mode.
    set_mode(1'b1);
    do_press(3'b001, 8'h05, 8, 0, 0);
    do_press(3'b001, 8'hFB, 8, 0, 0);
    do_press(3'b001, 8'h20, 8, 0, 0);
    chk("seq_done", {30'd0, o_state}, 32'd3);
    chk("seq_b", {24'd0, o_data_b}, 32'hFB);
    do_press(3'b001, 8'h77, 8, 0, 0);
    chk("seq_wrap_v", {31'd0, o_valid}, 32'd0);
    do_press(3'b001, 8'h11, 8, 0, 0);
    do_press(3'b001, 8'h22, 8, 0, 0);
    do_press(3'b010, 8'h99, 8, 0, 0);        // back S_OP -> S_B
    chk("back_st", {30'd0, o_state}, 32'd1);
    do_press(3'b001, 8'h33, 8, 0, 0);
    do_press(3'b101, 8'h44, 8, 0, 0);        // enter + clear
    chk("clr_a", {24'd0, o_data_a}, 32'd0);
    do_press(3'b001, 8'h0C, 8, 0, 0);
    do_press(3'b001, 8'h0D, 8, 0, 0);
    do_press(3'b001, 8'h0E, 8, 1, 0);        // mode flip on the load edge

    // Random transactions.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) set_mode(~m_mode);
      mk = 3'($urandom_range(1, 7));
      h  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(7, 12));
      tg = ($urandom_range(0, 9) == 0);
      do_press(mk, 8'($urandom), h, tg, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
